// File: rtl/wave_dac_pkg.sv
// Shared types for the waveform DAC generator: waveform mode and triangle direction.
package wave_dac_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF    = 2'd0,
    MODE_SAW    = 2'd1,
    MODE_TRI    = 2'd2,
    MODE_SQUARE = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/wave_dac_gen_prescaler.sv
// Sample-rate prescaler: step_en fires once every div+1 enabled cycles.
module tick_prescaler #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             step_en
);

  logic [DIV_W-1:0] count_q, count_d;

  assign step_en = enable && (count_q == div);

  always_comb begin
    count_d = count_q;
    if (clear || step_en) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/wave_dac_gen.sv
// Waveform generator (OFF/SAW/TRI/SQUARE) driving a parallel R-2R DAC, with a
// one-deep shadowed configuration that is applied at a safe point in the waveform.
module wave_dac_gen
  import wave_dac_pkg::*;
#(
  parameter int unsigned DAC_W = 8,
  parameter int unsigned DIV_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [MODE_W-1:0] cfg_mode,
  input  logic [DAC_W-1:0]  cfg_step,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic [DAC_W-1:0]  dac_out,
  output logic              tick,
  output logic              period_done
);

  localparam logic [DAC_W-1:0] MAX = '1;

  mode_e            mode_q, mode_d, sh_mode_q, sh_mode_d;
  logic [DAC_W-1:0] step_q, step_d, sh_step_q, sh_step_d;
  logic [DIV_W-1:0] div_q, div_d, sh_div_q, sh_div_d;
  logic [DAC_W-1:0] phase_q, phase_d, dac_q, dac_d;
  dir_e             dir_q, dir_d;
  logic             tick_q, tick_d, pd_q, pd_d, pend_q, pend_d;
  logic             step_en, apply, transfer;
  logic [DAC_W:0]   sum;

  assign sum      = {1'b0, phase_q} + {1'b0, step_q};
  assign transfer = cfg_valid && !pend_q;
  // A frozen or silent generator has no period boundary to wait for.
  assign apply    = pend_q && (pd_q || !enable || mode_q == MODE_OFF || step_q == '0);

  tick_prescaler #(.DIV_W(DIV_W)) u_presc (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .clear  (apply),
    .div    (div_q),
    .step_en(step_en)
  );

  always_comb begin
    mode_d    = mode_q;
    step_d    = step_q;
    div_d     = div_q;
    sh_mode_d = sh_mode_q;
    sh_step_d = sh_step_q;
    sh_div_d  = sh_div_q;
    phase_d   = phase_q;
    dir_d     = dir_q;
    dac_d     = dac_q;
    pend_d    = pend_q;
    tick_d    = 1'b0;
    pd_d      = 1'b0;
    if (apply) begin
      mode_d  = sh_mode_q;
      step_d  = sh_step_q;
      div_d   = sh_div_q;
      phase_d = '0;
      dir_d   = DIR_UP;
      dac_d   = '0;
      pend_d  = 1'b0;
    end else begin
      if (transfer) begin
        sh_mode_d = mode_e'(cfg_mode);
        sh_step_d = cfg_step;
        sh_div_d  = cfg_div;
        pend_d    = 1'b1;
      end
      if (step_en) begin
        tick_d = 1'b1;
        unique case (mode_q)
          MODE_OFF: dac_d = '0;
          MODE_SAW: begin
            phase_d = sum[DAC_W-1:0];
            dac_d   = sum[DAC_W-1:0];
            pd_d    = sum[DAC_W];
          end
          MODE_TRI: begin
            if (dir_q == DIR_UP) begin
              if (sum >= {1'b0, MAX}) begin
                phase_d = MAX;
                dir_d   = DIR_DOWN;
              end else begin
                phase_d = sum[DAC_W-1:0];
              end
            end else if (phase_q <= step_q) begin
              phase_d = '0;
              dir_d   = DIR_UP;
              pd_d    = 1'b1;
            end else begin
              phase_d = phase_q - step_q;
            end
            dac_d = phase_d;
          end
          MODE_SQUARE: begin
            phase_d = sum[DAC_W-1:0];
            dac_d   = phase_q[DAC_W-1] ? '0 : MAX;
            pd_d    = sum[DAC_W];
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= MODE_OFF;
      step_q    <= DAC_W'(1);
      div_q     <= '0;
      sh_mode_q <= MODE_OFF;
      sh_step_q <= '0;
      sh_div_q  <= '0;
      phase_q   <= '0;
      dir_q     <= DIR_UP;
      dac_q     <= '0;
      tick_q    <= 1'b0;
      pd_q      <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      step_q    <= step_d;
      div_q     <= div_d;
      sh_mode_q <= sh_mode_d;
      sh_step_q <= sh_step_d;
      sh_div_q  <= sh_div_d;
      phase_q   <= phase_d;
      dir_q     <= dir_d;
      dac_q     <= dac_d;
      tick_q    <= tick_d;
      pd_q      <= pd_d;
      pend_q    <= pend_d;
    end
  end

  assign dac_out     = dac_q;
  assign tick        = tick_q;
  assign period_done = pd_q;
  assign cfg_ready   = !pend_q;

endmodule

// File: tb/tb_wave_dac_gen.sv
// Bench for wave_dac_gen: cycle-level behavioural model checked every cycle,
// plus directed waveform sequences with hand-computed values.
module tb_wave_dac_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_mode = '0;
  logic [7:0]  cfg_step = '0;
  logic [15:0] cfg_div = '0;
  logic [7:0]  dac_out;
  logic        tick, period_done;

  int total = 0;
  int bad = 0;
  bit chk_en = 0;

  wave_dac_gen #(.DAC_W(8), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_mode(cfg_mode), .cfg_step(cfg_step), .cfg_div(cfg_div),
    .dac_out(dac_out), .tick(tick), .period_done(period_done)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on the waveform rules.
  int m_mode = 0, m_step = 1, m_div = 0, m_cnt = 0, m_phase = 0, m_dac = 0;
  int s_mode = 0, s_step = 0, s_div = 0;
  bit m_up = 1, m_tick = 0, m_pd = 0, m_pend = 0;

  always @(posedge clk) begin : model
    bit apply, fire;
    int p;
    if (rst) begin
      m_mode = 0; m_step = 1; m_div = 0; m_cnt = 0; m_phase = 0; m_dac = 0;
      s_mode = 0; s_step = 0; s_div = 0;
      m_up = 1; m_tick = 0; m_pd = 0; m_pend = 0;
    end else begin
      apply = m_pend && (m_pd || !enable || m_mode == 0 || m_step == 0);
      fire  = enable && (m_cnt == m_div);
      m_tick = 0;
      m_pd = 0;
      if (apply) begin
        m_mode = s_mode; m_step = s_step; m_div = s_div;
        m_phase = 0; m_up = 1; m_cnt = 0; m_dac = 0; m_pend = 0;
      end else begin
        if (cfg_valid && !m_pend) begin
          s_mode = int'(cfg_mode); s_step = int'(cfg_step); s_div = int'(cfg_div);
          m_pend = 1;
        end
        if (fire) m_cnt = 0;
        else if (enable) m_cnt = m_cnt + 1;
        if (fire) begin
          m_tick = 1;
          p = m_phase + m_step;
          case (m_mode)
            0: m_dac = 0;
            1: begin
              m_pd = (p > 255);
              m_phase = p % 256;
              m_dac = m_phase;
            end
            2: begin
              if (m_up) begin
                if (p >= 255) begin m_phase = 255; m_up = 0; end
                else m_phase = p;
              end else if (m_phase <= m_step) begin
                m_phase = 0; m_up = 1; m_pd = 1;
              end else begin
                m_phase = m_phase - m_step;
              end
              m_dac = m_phase;
            end
            default: begin
              m_dac = (m_phase < 128) ? 255 : 0;
              m_pd = (p > 255);
              m_phase = p % 256;
            end
          endcase
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      total++;
      if (int'(dac_out) != m_dac || tick !== m_tick || period_done !== m_pd ||
          cfg_ready !== !m_pend) begin
        bad++;
        $display("FAIL cycle t=%0t dac/tick/pd/ready got %0d/%0b/%0b/%0b expected %0d/%0b/%0b/%0b",
                 $time, dac_out, tick, period_done, cfg_ready, m_dac, m_tick, m_pd, !m_pend);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic next_tick(output int v, output int p, output int w);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (tick !== 1'b1 && w < 300);
    if (tick !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL tick_timeout: no tick within %0d cycles", w);
    end
    v = int'(dac_out);
    p = int'(period_done);
  endtask

  task automatic send_cfg(input int mode, input int step, input int div);
    int n = 0;
    while (cfg_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (cfg_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL cfg_ready_timeout: ready stayed low for %0d cycles", n);
    end
    cfg_valid = 1'b1;
    cfg_mode = 2'(mode);
    cfg_step = 8'(step);
    cfg_div = 16'(div);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  int v, p, w;
  int tri_exp[6] = '{100, 200, 255, 155, 55, 0};
  int sq_exp[4] = '{255, 255, 0, 0};

  initial begin
    repeat (3) @(negedge clk);
    chk_en = 1;
    check("rst_dac", int'(dac_out), 0);
    check("rst_tick", int'(tick), 0);
    check("rst_pd", int'(period_done), 0);
    check("rst_ready", int'(cfg_ready), 1);
    rst = 1'b0;

    // SAW step 1, div 0
    send_cfg(1, 1, 0);
    for (int i = 1; i <= 255; i++) begin
      next_tick(v, p, w);
      if (i <= 3) begin
        check("saw_val", v, i);
        check("saw_gap", w, (i == 1) ? 2 : 1);
      end
    end
    check("saw_255", v, 255);
    next_tick(v, p, w);
    check("saw_wrap_val", v, 0);
    check("saw_wrap_pd", p, 1);

    // TRI step 100, div 3
    enable = 1'b0;
    send_cfg(2, 100, 3);
    @(negedge clk);
    enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      next_tick(v, p, w);
      check("tri_val", v, tri_exp[i]);
      check("tri_gap", w, 4);
      check("tri_pd", p, (i == 5) ? 1 : 0);
    end

    // Mid-TRI reconfiguration to SAW step 2
    next_tick(v, p, w);
    check("tri_again", v, 100);
    send_cfg(1, 2, 0);
    check("pend_ready_low", int'(cfg_ready), 0);
    for (int i = 0; i < 10 && p == 0; i++) next_tick(v, p, w);
    check("tri_pd_seen", p, 1);
    check("tri_pd_dac", v, 0);
    check("ready_low_at_pd", int'(cfg_ready), 0);
    @(negedge clk);
    check("apply_dac", int'(dac_out), 0);
    check("apply_tick", int'(tick), 0);
    check("apply_ready", int'(cfg_ready), 1);
    next_tick(v, p, w);
    check("saw2_first", v, 2);
    check("saw2_gap", w, 1);

    // SQUARE step 64, div 0
    enable = 1'b0;
    send_cfg(3, 64, 0);
    @(negedge clk);
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      next_tick(v, p, w);
      check("sq_val", v, sq_exp[i % 4]);
      check("sq_pd", p, (i % 4 == 3) ? 1 : 0);
    end

    // Enable freeze at 37, SAW div 4
    enable = 1'b0;
    send_cfg(1, 1, 4);
    @(negedge clk);
    enable = 1'b1;
    v = 0;
    for (int i = 0; i < 100 && v != 37; i++) next_tick(v, p, w);
    check("freeze_reach", v, 37);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("freeze_dac", int'(dac_out), 37);
      check("freeze_tick", int'(tick), 0);
    end
    enable = 1'b1;
    next_tick(v, p, w);
    check("resume_val", v, 38);
    check("resume_gap", w, 5);

    // Reset with a config pending in TRI
    enable = 1'b0;
    send_cfg(2, 50, 1);
    @(negedge clk);
    enable = 1'b1;
    repeat (3) next_tick(v, p, w);
    send_cfg(1, 3, 0);
    check("pend_before_rst", int'(cfg_ready), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst2_dac", int'(dac_out), 0);
    check("rst2_tick", int'(tick), 0);
    check("rst2_pd", int'(period_done), 0);
    check("rst2_ready", int'(cfg_ready), 1);
    rst = 1'b0;
    begin
      int maxv = 0, ticks = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (int'(dac_out) > maxv) maxv = int'(dac_out);
        ticks += int'(tick);
      end
      check("off_after_rst_max", maxv, 0);
      check("off_after_rst_ticks", ticks, 20);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      enable = ($urandom_range(0, 9) != 0);
      cfg_valid = ($urandom_range(0, 19) == 0);
      cfg_mode = 2'($urandom_range(0, 3));
      cfg_step = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      cfg_div = 16'($urandom_range(0, 3));
      rst = ($urandom_range(0, 499) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    cfg_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wave_dac_gen.md
WAVE_DAC_GEN -- requirements
Module: wave_dac_gen

Interface
REQ-001 Parameter DAC_W, default 8, width of the DAC code and step size; legal range 4..16.
REQ-002 Parameter DIV_W, default 16, width of the sample-rate prescaler divisor.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  run control; low freezes prescaler, phase and output.
REQ-006 cfg_valid  input  1  configuration offer.
REQ-007 cfg_ready  output  1  configuration slot free.
REQ-008 cfg_mode  input  2  0 OFF, 1 SAW, 2 TRI, 3 SQUARE.
REQ-009 cfg_step  input  DAC_W  phase increment per sample.
REQ-010 cfg_div  input  DIV_W  one sample every cfg_div+1 clk cycles.
REQ-011 dac_out  output  DAC_W  registered code to the parallel R-2R DAC pins.
REQ-012 tick  output  1  one-cycle pulse, high in the first cycle that a new dac_out value is present.
REQ-013 period_done  output  1  one-cycle pulse coincident with tick when a waveform period completes.

Function
REQ-014 Prescaler counts 0..div_r while enable=1; step_en = enable && count==div_r; on step_en, count returns to 0; div_r=0 gives step_en every cycle.
REQ-015 On the step_en edge, phase and dac_out update and tick is registered to 1; total latency from step_en to visible output is 1 cycle.
REQ-016 SAW: phase <= phase+step_r mod 2^DAC_W; dac_out <= new phase; period_done on carry-out.
REQ-017 TRI, rising: if phase+step_r >= MAX (2^DAC_W-1), then phase <= MAX and dir <= down; otherwise phase <= phase+step_r.
REQ-018 TRI, falling: if phase <= step_r, then phase <= 0, dir <= up and period_done is asserted; otherwise phase <= phase-step_r; no wrap-around in TRI mode.
REQ-019 SQUARE: phase advances as in SAW; dac_out <= MAX when phase MSB=0, else 0; period_done on carry-out.
REQ-020 OFF: dac_out held at 0; tick is still generated; period_done is never asserted.
REQ-021 Handshake: a transfer occurs when cfg_valid && cfg_ready; fields are captured into shadow registers, pending <= 1; cfg_ready = !pending.
REQ-022 Pending config is applied at the first period_done, or on the next cycle if enable=0, mode_r=OFF, or step_r=0.
REQ-023 Apply action: mode_r/step_r/div_r <= shadow; phase <= 0; dir <= up; prescaler <= 0; dac_out <= 0; pending <= 0.
REQ-024 When apply and transfer coincide in one cycle, the apply takes precedence; cfg_ready rises the following cycle and there is no same-cycle re-accept.
REQ-025 step_r=0 freezes phase in every mode; tick pulses continue.
REQ-026 When enable falls mid-period, all state is held exactly; on resume, counting continues from the held count.

Reset
REQ-027 While rst=1: dac_out=0, tick=0, period_done=0, cfg_ready=1, pending=0, mode_r=OFF, step_r=1, div_r=0, phase=0, dir=up, prescaler=0.
REQ-028 Reset mid-period or with a config pending discards all state, including the shadow registers; the first tick after reset occurs no earlier than the cycle after rst falls.

Structure
REQ-029 Package wave_dac_pkg holds the mode enum (OFF/SAW/TRI/SQUARE) and the mode field width constant.
REQ-030 A single sub-module, tick_prescaler (parameter DIV_W, inputs clk/rst/enable/clear/div, output step_en), implements the prescaler.
REQ-031 No derived or gated clocks; sample rate is produced only by the step_en clock enable.

Verification
REQ-032 DAC_W=8, SAW, step=1, div=0, enable=1 -> dac_out 1,2,…,255,0 on consecutive cycles; period_done with the 0 sample (every 256 ticks).
REQ-033 TRI, step=100, div=3 -> dac_out 100,200,255,155,55,0 with ticks 4 cycles apart; period_done on the 0 sample.
REQ-034 SQUARE, step=64, div=0 -> dac_out 255,255,0,0 repeating; period_done every 4th tick.
REQ-035 Mid-TRI, offer SAW step=2 -> cfg_ready low until period_done; then dac_out=0, next tick gives 2.
REQ-036 enable dropped for 10 cycles at dac_out=37 (SAW, div=4) -> output stays 37 with no tick; counting resumes with an unchanged prescaler count.
REQ-037 rst pulsed while config pending in TRI -> all outputs at reset values, cfg_ready=1, mode OFF, shadow discarded.
